// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : univ_shift_reg
//  Description : Parametrised universal shift register (hold / shift right /
//                shift left / parallel load) with serial outputs at both ends,
//                a shared shift counter and a per-word completion pulse.
//                Acts as the SERDES element between serial links and
//                word-wide datapaths.
//  Optional    : USR_PARITY_EN - when defined, parity is a register that
//                always equals ^q; when undefined, parity is tied to 0.
//                The port list is the same in both builds.
//  Ports       : clk        rising-edge clock
//                reset      synchronous, active-high reset
//                en         clock enable (0 = all state holds)
//                mode       00 hold, 01 shift right, 10 shift left, 11 load
//                sin_r      serial input entering at MSB on a right shift
//                sin_l      serial input entering at LSB on a left shift
//                d          parallel load data
//                q          register contents
//                sout_r     q[0], bit leaving on a right shift
//                sout_l     q[WIDTH-1], bit leaving on a left shift
//                shift_cnt  shifts since last load, reset or word completion
//                word_done  one-cycle pulse after WIDTH shifts
//                parity     XOR of q (optional, see above)
//  Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done,
    output logic             parity
);

    localparam logic [1:0]       c_MODE_HOLD  = 2'b00;
    localparam logic [1:0]       c_MODE_RIGHT = 2'b01;
    localparam logic [1:0]       c_MODE_LEFT  = 2'b10;
    localparam logic [1:0]       c_MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_word_done;

    logic [WIDTH-1:0] w_q_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_done_next;
    logic             w_shift;

    // Both shift directions advance the same word counter.
    assign w_shift = en && ((mode == c_MODE_RIGHT) || (mode == c_MODE_LEFT));

    always_comb begin
        w_q_next    = r_q;
        w_cnt_next  = r_cnt;
        w_done_next = 1'b0;
        if (en) begin
            case (mode)
                c_MODE_HOLD:  w_q_next = r_q;
                c_MODE_RIGHT: w_q_next = {sin_r, r_q[WIDTH-1:1]};
                c_MODE_LEFT:  w_q_next = {r_q[WIDTH-2:0], sin_l};
                c_MODE_LOAD:  w_q_next = d;
                default:      w_q_next = r_q;
            endcase
        end
        if (w_shift) begin
            // Wrapping on the last shift of a word lets back-to-back words
            // pulse word_done every WIDTH shifts without a gap.
            if (r_cnt == c_CNT_LAST) begin
                w_cnt_next  = '0;
                w_done_next = 1'b1;
            end else begin
                w_cnt_next  = r_cnt + 1'b1;
            end
        end else if (en && (mode == c_MODE_LOAD)) begin
            // A load discards any partial word without reporting it.
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q         <= '0;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_q         <= w_q_next;
            r_cnt       <= w_cnt_next;
            r_word_done <= w_done_next;
        end
    end

`ifdef USR_PARITY_EN
    logic r_parity;

    // Loaded from the next value of q so it tracks ^q with no extra latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= ^w_q_next;
        end
    end

    assign parity = r_parity;
`else
    assign parity = 1'b0;
`endif

    assign q         = r_q;
    assign sout_r    = r_q[0];
    assign sout_l    = r_q[WIDTH-1];
    assign shift_cnt = r_cnt;
    assign word_done = r_word_done;

endmodule
`default_nettype wire
